seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits (DE2 polarity, segment 0 = lit).
//  Holds a double-buffered display value and drives the decoder nibble.
//  Registers the returned segment code and sequences the digit enables, with an anti-ghosting gap between digits.
//  Sits between the user datapath (value producer) and the board display pins.
// PARAMETERS
//  NUM_DIGITS  4      number of multiplexed digits (>=2)
//  SCAN_DIV    50000  clocks each digit is lit per slot (>=1)
//  DIV_W       16     hold-counter width; must hold SCAN_DIV-1
// PORTS
//  Clk         in   1             system clock, rising edge
//  Reset       in   1             synchronous, active-high reset
//  Load        in   1             strobe: capture Value into shadow register
//  Value       in   4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost)
//  Blank_Mask  in   NUM_DIGITS    bit i=1 forces digit i dark (sampled live)
//  Dec_In      out  4             nibble to shared decoder input
//  Dec_Out     in   7             decoder output, active-low {a..g}
//  Seg         out  7             registered segment pins, active-low
//  Digit_En    out  NUM_DIGITS    one-hot active-low digit enable
//  Busy        out  1             shadow value pending, not yet displayed
//  Frame_Done  out  1             1-cycle pulse at end of each full scan
// BEHAVIOUR
//  Reset: state=GAP, idx=0, active=0, shadow=0, pending=0; Seg=7'h7F, Digit_En=all 1, Dec_In=0, Busy=0, Frame_Done=0.
//  Reset mid-frame abandons the frame; takes effect at the next edge.
//  FSM: GAP -> LATCH -> HOLD -> GAP.
//   GAP (1 clk): Digit_En=all 1, Seg=7'h7F, Dec_In<=active[idx]; idx is already advanced.
//   LATCH (1 clk): Seg<=Dec_Out, Digit_En<=~(1<<idx), cnt<=0.
//     If digit idx is blanked: Seg<=7'h7F and Digit_En stays all 1.
//   HOLD: cnt++ each clk. At cnt==SCAN_DIV-1: go GAP, idx<=idx+1.
//     idx wraps NUM_DIGITS-1 -> 0.
//  Slot = SCAN_DIV+2 clks; frame = NUM_DIGITS*(SCAN_DIV+2) clks. Digit_En never has >1 bit low.
//  Dec_In is held stable during LATCH; the decoder is combinational, 0-cycle.
//  Wrap (HOLD->GAP from idx=NUM_DIGITS-1): Frame_Done=1 for that cycle.
//    If pending: active<=shadow, pending<=0.
//  Load: shadow<=Value, pending<=1, Busy=pending (registered).
//    Load while pending overwrites shadow (last wins).
//    Load in the same cycle as the wrap: active<=Value and shadow<=Value, pending<=0.
//  Display is never torn: active changes only at the frame wrap.
//  Blanked digit i = Blank_Mask[i]=1, or a leading-zero condition (below).
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    digit i (i>0) is blanked when active nibbles i..NUM_DIGITS-1 are all 0.
//    Digit 0 is always shown, so a value of 0 displays "0".
//  Not defined: all digits are shown unless masked.
//  The blanking decision is evaluated on active at LATCH.
// TESTING (NUM_DIGITS=4, SCAN_DIV=3: slot=5, frame=20 clks)
//  Reset held 2 clks -> Seg=7'h7F, Digit_En=4'hF, Busy=0, Frame_Done=0; GAP on release.
//  Load 16'h1234, run 2 frames ->
//    second frame: idx0 Seg=7'b100_1100 with Digit_En=4'b1110;
//    idx1 Seg=7'b000_0110 with 4'b1101; Frame_Done every 20 clks.
//  Load 16'hABCD mid-frame -> Busy=1 and old digits persist until Frame_Done;
//    then Busy=0 and idx0 shows 7'b100_0010.
//  Blank_Mask=4'b0100 -> idx2 slot has Digit_En=4'hF and Seg=7'h7F; other slots unaffected.
//  LEADING_ZERO_BLANK_EN, Value 16'h0050 -> idx3 and idx2 dark;
//    idx1=7'b010_0100, idx0=7'b000_0001.
//    16'h0000 -> only idx0 lit, showing 7'b000_0001.
//  Reset during HOLD of idx2 with pending=1 -> next clk: blank outputs, idx=0, Busy=0;
//    display shows 0 after the first frame.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Scans NUM_DIGITS common-anode digits through one shared, external hex to
// 7-segment decoder. Each digit slot is GAP (all dark, decoder nibble loaded),
// LATCH (decoder result captured), then SCAN_DIV clocks of HOLD with the digit lit.
// A new display value is captured into a shadow register and only becomes
// the active value at the frame wrap, so a frame is never torn.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits
// (digit 0 is always shown).
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DIV_W      = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Load,
   input  logic [4*NUM_DIGITS-1:0] Value,
   input  logic [NUM_DIGITS-1:0]   Blank_Mask,
   output logic [3:0]              Dec_In,
   input  logic [6:0]              Dec_Out,
   output logic [6:0]              Seg,
   output logic [NUM_DIGITS-1:0]   Digit_En,
   output logic                    Busy,
   output logic                    Frame_Done
);

   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0]  CNT_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [6:0]        SEG_OFF  = 7'h7F;

   typedef enum logic [1:0] {
      ST_GAP   = 2'd0,
      ST_LATCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DIV_W-1:0]        cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic                    pending_q, pending_d;
   logic [3:0]              dec_in_q, dec_in_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   en_q, en_d;

   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   digit_blank;
   logic [NUM_DIGITS-1:0]   en_sel_n;
   logic                    frame_wrap;

   // Per-digit nibble slices, blanking decisions and active-low enable pattern.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]      = active_q[4*gi +: 4];
         assign en_sel_n[gi] = (idx_q != IDX_W'(gi));
`ifdef LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_lsd
            // The rightmost digit is always shown so zero still reads "0".
            assign digit_blank[gi] = Blank_Mask[gi];
         end else begin : g_msd
            assign digit_blank[gi] = Blank_Mask[gi] |
                                     (active_q[4*NUM_DIGITS-1:4*gi] == '0);
         end
`else
         assign digit_blank[gi] = Blank_Mask[gi];
`endif
      end
   endgenerate

   // Last HOLD clock of the last digit closes the frame.
   assign frame_wrap = (state_q == ST_HOLD) && (cnt_q == CNT_LAST) &&
                       (idx_q == LAST_IDX);

   // Scan sequencer: next state, digit index, hold counter and pin values.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      dec_in_d = dec_in_q;
      seg_d    = seg_q;
      en_d     = en_q;
      unique case (state_q)
         ST_GAP: begin
            // Present the nibble now so the decoder settles before LATCH.
            dec_in_d = nib[idx_q];
            state_d  = ST_LATCH;
         end
         ST_LATCH: begin
            cnt_d   = '0;
            state_d = ST_HOLD;
            if (digit_blank[idx_q]) begin
               seg_d = SEG_OFF;
               en_d  = '1;
            end else begin
               seg_d = Dec_Out;
               en_d  = en_sel_n;
            end
         end
         ST_HOLD: begin
            if (cnt_q == CNT_LAST) begin
               // Turn the digit off first; the next one lights after a gap.
               state_d = ST_GAP;
               seg_d   = SEG_OFF;
               en_d    = '1;
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_GAP;
            seg_d   = SEG_OFF;
            en_d    = '1;
         end
      endcase
   end

   // Double buffer: loads park in shadow, active swaps only at the frame wrap.
   always_comb begin
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (frame_wrap) begin
         if (Load) begin
            active_d = Value;
            shadow_d = Value;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (Load) begin
         shadow_d  = Value;
         pending_d = 1'b1;
      end
   end

   // State and output registers with synchronous reset to a dark display.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_GAP;
         idx_q     <= '0;
         cnt_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         dec_in_q  <= 4'h0;
         seg_q     <= SEG_OFF;
         en_q      <= '1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         dec_in_q  <= dec_in_d;
         seg_q     <= seg_d;
         en_q      <= en_d;
      end
   end

   assign Dec_In     = dec_in_q;
   assign Seg        = seg_q;
   assign Digit_En   = en_q;
   assign Busy       = pending_q;
   assign Frame_Done = frame_wrap;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Drives directed and random Load/Blank_Mask/Reset traffic. A frame-level
// model (display value committed at each frame boundary, fixed slot timing)
// pushes the expected pin state for every clock into a queue; an independent
// monitor pops one entry per clock and compares it with the DUT pins.
module tb_seven_seg_scan_ctrl;

   localparam int NUM_DIGITS = 4;
   localparam int SCAN_DIV   = 3;
   localparam int DIV_W      = 2;
   localparam int SLOT       = SCAN_DIV + 2;
   localparam int FRAME      = NUM_DIGITS * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic [3:0]  dec_in;
   logic [6:0]  dec_out;
   logic [6:0]  seg;
   logic [3:0]  digit_en;
   logic        busy;
   logic        frame_done;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .DIV_W      (DIV_W)
   ) dut (
      .Clk        (clk),
      .Reset      (rst),
      .Load       (load),
      .Value      (value),
      .Blank_Mask (blank_mask),
      .Dec_In     (dec_in),
      .Dec_Out    (dec_out),
      .Seg        (seg),
      .Digit_En   (digit_en),
      .Busy       (busy),
      .Frame_Done (frame_done)
   );

   // Board decoder stand-in: active-low {a,b,c,d,e,f,g}.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b000_0001;
         4'h1: return 7'b100_1111;
         4'h2: return 7'b001_0010;
         4'h3: return 7'b000_0110;
         4'h4: return 7'b100_1100;
         4'h5: return 7'b010_0100;
         4'h6: return 7'b010_0000;
         4'h7: return 7'b000_1111;
         4'h8: return 7'b000_0000;
         4'h9: return 7'b000_0100;
         4'hA: return 7'b000_1000;
         4'hB: return 7'b110_0000;
         4'hC: return 7'b011_0001;
         4'hD: return 7'b100_0010;
         4'hE: return 7'b011_0000;
         default: return 7'b011_1000;
      endcase
   endfunction

   assign dec_out = hex7(dec_in);

   typedef struct {
      int         cyc;
      logic [6:0] seg;
      logic [3:0] en;
      logic       busy;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   t_cyc  = 0;

   // Reference model state.
   int          m_cyc      = 0;
   logic [15:0] m_shown    = 16'h0;
   logic [15:0] m_latest   = 16'h0;
   bit          m_pend     = 1'b0;
   logic [6:0]  m_slot_seg = 7'h7F;
   logic [3:0]  m_slot_en  = 4'hF;

   function automatic bit digit_dark(input logic [15:0] v, input int i,
                                     input logic [3:0] mask);
      if (mask[i]) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && (v >> (4 * i)) == 16'h0) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // One clock of stimulus; the expected pins for this clock go to the queue.
   task automatic cycle(input bit r, input bit ld, input logic [15:0] val,
                        input logic [3:0] mask);
      exp_t        e;
      int          o;
      int          s;
      logic [3:0]  nb;
      @(negedge clk);
      rst        = r;
      load       = ld;
      value      = val;
      blank_mask = mask;
      if (ld && !r)
         $display("load value=%h cycle=%0d frame_pos=%0d", val, t_cyc, m_cyc);
      o = m_cyc % SLOT;
      s = m_cyc / SLOT;
      if (o == 1) begin
         if (digit_dark(m_shown, s, mask)) begin
            m_slot_seg = 7'h7F;
            m_slot_en  = 4'hF;
         end else begin
            nb         = 4'(m_shown >> (4 * s));
            m_slot_seg = hex7(nb);
            m_slot_en  = ~(4'b0001 << s);
         end
      end
      e.cyc  = t_cyc;
      e.busy = m_pend;
      e.fd   = (m_cyc == FRAME - 1);
      if (o < 2) begin
         e.seg = 7'h7F;
         e.en  = 4'hF;
      end else begin
         e.seg = m_slot_seg;
         e.en  = m_slot_en;
      end
      exp_q.push_back(e);
      // Effect of the upcoming clock edge.
      if (r) begin
         m_cyc    = 0;
         m_shown  = 16'h0;
         m_latest = 16'h0;
         m_pend   = 1'b0;
      end else begin
         if (m_cyc == FRAME - 1) begin
            if (ld) begin
               m_shown  = val;
               m_latest = val;
            end else if (m_pend) begin
               m_shown = m_latest;
            end
            m_pend = 1'b0;
         end else if (ld) begin
            m_latest = val;
            m_pend   = 1'b1;
         end
         m_cyc = (m_cyc + 1) % FRAME;
      end
      t_cyc++;
   endtask

   task automatic idle(input int n, input logic [3:0] mask);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 16'h0, mask);
   endtask

   task automatic chk(input string name, input int cyc, input logic [15:0] act,
                      input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, req);
      end
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      int          lz;
      v  = 16'($urandom);
      lz = $urandom_range(0, 4);
      return v & (16'hFFFF >> (4 * lz));
   endfunction

   // Monitor: one expected entry per clock, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("seg",        mon_e.cyc, {9'h0, seg},         {9'h0, mon_e.seg});
            chk("digit_en",   mon_e.cyc, {12'h0, digit_en},   {12'h0, mon_e.en});
            chk("busy",       mon_e.cyc, {15'h0, busy},       {15'h0, mon_e.busy});
            chk("frame_done", mon_e.cyc, {15'h0, frame_done}, {15'h0, mon_e.fd});
         end
      end
   end

   // Stimulus.
   initial begin
      bit          r;
      bit          ld;
      logic [3:0]  mask;
      rst        = 1'b1;
      load       = 1'b0;
      value      = 16'h0;
      blank_mask = 4'h0;

      cycle(1'b1, 1'b0, 16'h0, 4'h0);
      cycle(1'b1, 1'b0, 16'h0, 4'h0);

      // Value 1234, two frames.
      cycle(1'b0, 1'b1, 16'h1234, 4'h0);
      idle(2 * FRAME - 1, 4'h0);

      // Mid-frame update to ABCD.
      idle(7, 4'h0);
      cycle(1'b0, 1'b1, 16'hABCD, 4'h0);
      idle(2 * FRAME, 4'h0);

      // Mask digit 2 for a full frame.
      idle(FRAME, 4'b0100);

      // Leading-zero patterns.
      cycle(1'b0, 1'b1, 16'h0050, 4'h0);
      idle(2 * FRAME, 4'h0);
      cycle(1'b0, 1'b1, 16'h0000, 4'h0);
      idle(2 * FRAME, 4'h0);

      // Load exactly on the wrap cycle.
      while (m_cyc != FRAME - 1) cycle(1'b0, 1'b0, 16'h0, 4'h0);
      cycle(1'b0, 1'b1, 16'h9E07, 4'h0);
      idle(FRAME, 4'h0);

      // Reset during HOLD of digit 2 with a load pending.
      while (m_cyc != 3) cycle(1'b0, 1'b0, 16'h0, 4'h0);
      cycle(1'b0, 1'b1, 16'h4321, 4'h0);
      while (m_cyc != 2 * SLOT + 2) cycle(1'b0, 1'b0, 16'h0, 4'h0);
      cycle(1'b1, 1'b0, 16'h0, 4'h0);
      idle(2 * FRAME, 4'h0);

      // Random traffic.
      mask = 4'h0;
      for (int k = 0; k < 800; k++) begin
         r  = ($urandom_range(0, 249) == 0);
         ld = (m_cyc == FRAME - 1) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
         cycle(r, ld, rand_val(), mask);
      end
      idle(FRAME, 4'h0);

      @(negedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
